// File: rtl/gigatron_rom_loader.sv
// Program ROM port arbiter: CPU fetch in normal operation, host byte-stream
// loader that halts the CPU and rewrites ROM words in place.
module gigatron_rom_loader #(
    parameter int unsigned ROM_SIZE = 131072
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [15:0] i_cpu_addr,
    output logic [15:0] o_cpu_data,
    output logic        o_cpu_valid,
    output logic        o_cpu_halt,
    input  logic        i_ld_start,
    input  logic [15:0] i_ld_addr,
    input  logic [15:0] i_ld_count,
    input  logic        i_ld_abort,
    input  logic        i_ld_valid,
    input  logic [7:0]  i_ld_byte,
    output logic        o_ld_ready,
    output logic        o_ld_busy,
    output logic        o_ld_done,
    output logic [15:0] o_rom_addr,
    output logic        o_rom_we,
    output logic [15:0] o_rom_wdata,
    input  logic [15:0] i_rom_rdata
);

    // Word-address mask: keeps the write pointer inside ROM_SIZE/2 words.
    localparam logic [15:0] ADDR_MASK = 16'(ROM_SIZE / 2 - 1);

    typedef enum logic [2:0] {
        StRun,
        StLdLo,
        StLdHi,
        StWrite,
        StFinish
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_ptr;
    logic [15:0] r_count;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic        r_cpu_valid;
    logic        w_ready;
    logic        w_xfer;

    assign w_xfer      = i_ld_valid & w_ready;
    assign o_ld_ready  = w_ready;
    assign o_cpu_valid = r_cpu_valid;
    assign o_cpu_data  = i_rom_rdata;
    assign o_rom_wdata = {r_hi, r_lo};

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StRun: begin
                if (i_ld_start) begin
                    w_state_next = (i_ld_count != 16'd0) ? StLdLo : StFinish;
                end
            end
            StLdLo: begin
                if (i_ld_abort)      w_state_next = StRun;
                else if (i_ld_valid) w_state_next = StLdHi;
            end
            StLdHi: begin
                if (i_ld_abort)      w_state_next = StRun;
                else if (i_ld_valid) w_state_next = StWrite;
            end
            StWrite: begin
                if (i_ld_abort)              w_state_next = StRun;
                else if (r_count == 16'd1)   w_state_next = StFinish;
                else                         w_state_next = StLdLo;
            end
            StFinish: w_state_next = StRun;
            default:  w_state_next = StRun;
        endcase
    end

    always_comb begin
        o_rom_addr = r_ptr;
        o_rom_we   = 1'b0;
        o_cpu_halt = 1'b1;
        o_ld_busy  = 1'b1;
        o_ld_done  = 1'b0;
        w_ready    = 1'b0;
        unique case (r_state)
            StRun: begin
                o_rom_addr = i_cpu_addr;
                o_cpu_halt = 1'b0;
                o_ld_busy  = 1'b0;
            end
            // Abort takes priority: the byte on the link is left unconsumed.
            StLdLo, StLdHi: w_ready = ~i_ld_abort;
            StWrite:        o_rom_we = 1'b1;
            StFinish:       o_ld_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr       <= 16'd0;
            r_count     <= 16'd0;
            r_lo        <= 8'd0;
            r_hi        <= 8'd0;
            r_cpu_valid <= 1'b0;
        end else begin
            r_cpu_valid <= (r_state == StRun);
            if (r_state == StRun && i_ld_start && i_ld_count != 16'd0) begin
                r_ptr   <= i_ld_addr & ADDR_MASK;
                r_count <= i_ld_count;
            end
            if (r_state == StLdLo && w_xfer) r_lo <= i_ld_byte;
            if (r_state == StLdHi && w_xfer) r_hi <= i_ld_byte;
            if (r_state == StWrite) begin
                r_ptr   <= (r_ptr + 16'd1) & ADDR_MASK;
                r_count <= r_count - 16'd1;
            end
        end
    end

endmodule
